// File: rtl/and_gate_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : and_gate_ctrl_pkg
// Brief    : Shared types, vector limits and expected-response helper for the
//            controlled AND gate sweeper.
// Revision : 1.0 - initial release
// ============================================================================
package and_gate_ctrl_pkg;

    localparam int              VEC_W     = 17;
    localparam logic [VEC_W-1:0] LAST_FULL = 17'h1FFFF;
    localparam logic [VEC_W-1:0] LAST_LSB  = 17'd31;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_APPLY = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Vector layout is {ctrl, d[3:0], c[3:0], b[3:0], a[3:0]}; only bit 0 of each operand matters.
    function automatic logic exp_out(input logic [VEC_W-1:0] vec);
        return vec[16] ^ (vec[0] & vec[4] & vec[8] & vec[12]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/and_gate_ctrl_sweeper_if.sv
`default_nettype none
// ============================================================================
// Module   : and_gate_ctrl_sweeper_if
// Brief    : Stimulus/response bundle between the sweeper and the gate.
// Revision : 1.0 - initial release
// ============================================================================
interface and_gate_ctrl_sweeper_if;

    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
    logic [3:0] d;
    logic       ctrl;
    logic       dut_out;

    modport master (output a, output b, output c, output d, output ctrl, input dut_out);
    modport slave  (input a, input b, input c, input d, input ctrl, output dut_out);

endinterface
`default_nettype wire

// File: rtl/and_gate_ctrl_vec_gen.sv
`default_nettype none
// ============================================================================
// Module   : and_gate_ctrl_vec_gen
// Brief    : Vector index counter, index-to-vector mapping and last-vector flag.
// Revision : 1.0 - initial release
// ============================================================================
module and_gate_ctrl_vec_gen
    import and_gate_ctrl_pkg::*;
#(
    parameter int LSB_ONLY = 0
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_clr,
    input  wire logic             i_inc,
    output logic      [VEC_W-1:0] o_vec,
    output logic                  o_last
);

    logic [VEC_W-1:0] r_index;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_index <= '0;
        end else if (i_clr) begin
            r_index <= '0;
        end else if (i_inc && !o_last) begin
            r_index <= r_index + VEC_W'(1);
        end
    end

    generate
        if (LSB_ONLY != 0) begin : g_lsb
            // Index bits land on bit 0 of each operand; upper operand bits stay 0.
            assign o_vec  = {r_index[4], 3'b000, r_index[3], 3'b000, r_index[2],
                             3'b000, r_index[1], 3'b000, r_index[0]};
            assign o_last = (r_index == LAST_LSB);
        end else begin : g_full
            assign o_vec  = r_index;
            assign o_last = (r_index == LAST_FULL);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/and_gate_ctrl_sweeper.sv
`default_nettype none
// ============================================================================
// Module   : and_gate_ctrl_sweeper
// Brief    : Sweeps stimulus into the controlled AND gate and scores responses.
// Revision : 1.0 - initial release
// ============================================================================
module and_gate_ctrl_sweeper
    import and_gate_ctrl_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int LSB_ONLY      = 0,
    parameter int ERR_W         = 16
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 start,
    input  wire logic                 abort,
    and_gate_ctrl_sweeper_if.master   gate,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic      [ERR_W-1:0]     err_count,
    output logic      [VEC_W-1:0]     first_err_vec,
    output logic                      first_err_valid
);

    localparam int CNT_W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD =
        (SETTLE_CYCLES > 0) ? CNT_W'(SETTLE_CYCLES - 1) : '0;

    state_t           r_state;
    state_t           w_next;
    logic             w_clr;
    logic             w_inc;
    logic             w_abort;
    logic             w_ok;
    logic             w_exp;
    logic             w_last;
    logic [VEC_W-1:0] w_vec;
    logic [VEC_W-1:0] r_stim;
    logic [CNT_W-1:0] r_settle;

    and_gate_ctrl_vec_gen #(.LSB_ONLY(LSB_ONLY)) u_vec_gen (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_clr),
        .i_inc  (w_inc),
        .o_vec  (w_vec),
        .o_last (w_last)
    );

    assign gate.a    = r_stim[3:0];
    assign gate.b    = r_stim[7:4];
    assign gate.c    = r_stim[11:8];
    assign gate.d    = r_stim[15:12];
    assign gate.ctrl = r_stim[16];

    assign w_abort = abort && (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_clr  = 1'b0;
        w_inc  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    w_next = S_APPLY;
                    w_clr  = 1'b1;
                end
            end
            S_APPLY: w_next = (SETTLE_CYCLES == 0) ? S_CHECK : S_WAIT;
            S_WAIT:  if (r_settle == '0) w_next = S_CHECK;
            S_CHECK: begin
                if (w_last) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_APPLY;
                    w_inc  = 1'b1;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (w_abort) begin
            w_next = S_IDLE;
            w_inc  = 1'b0;
        end
    end

    // A response that is neither 0 nor 1 falls to the default arm and scores as a miss.
    always_comb begin
        w_exp = exp_out(r_stim);
        case (gate.dut_out)
            1'b0:    w_ok = ~w_exp;
            1'b1:    w_ok = w_exp;
            default: w_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stim          <= '0;
            r_settle        <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            if (w_abort) begin
                r_stim <= '0;
                busy   <= 1'b0;
                pass   <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            err_count       <= '0;
                            pass            <= 1'b0;
                            first_err_valid <= 1'b0;
                            busy            <= 1'b1;
                        end
                    end
                    S_APPLY: begin
                        r_stim   <= w_vec;
                        r_settle <= SETTLE_LOAD;
                    end
                    S_WAIT: begin
                        if (r_settle != '0) r_settle <= r_settle - CNT_W'(1);
                    end
                    S_CHECK: begin
                        if (!w_ok) begin
                            if (err_count != '1) err_count <= err_count + ERR_W'(1);
                            if (!first_err_valid) begin
                                first_err_vec   <= r_stim;
                                first_err_valid <= 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
                        done   <= 1'b1;
                        pass   <= (err_count == '0);
                        r_stim <= '0;
                        busy   <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
